// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// Optional round-robin tie-break is selected with SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

   localparam int ADDR_W_DEF = 23;
   localparam int DATA_W_DEF = 32;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } arb_state_e;

   function automatic logic [1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for two request ports.
// SDRAM_ARB_RR_EN: ties go to the port not granted last; otherwise port 0 wins ties.
module sdram_arb_pick
   import sdram_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

`ifdef SDRAM_ARB_RR_EN
   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) grant_o = port_onehot((last_i == P1) ? P0 : P1);
   end
`else
   logic unused_last;
   assign unused_last = last_i;

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) grant_o = port_onehot(P0);
   end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one sdram_controller user interface between two requesters, one op in flight.
// SDRAM_ARB_RR_EN builds the last-grant register for round-robin ties.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_rw,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        req_ready,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              sd_rw,
   output logic [DATA_W-1:0] sd_wdata,
   output logic              sd_in_valid,
   input  logic              sd_busy,
   input  logic [DATA_W-1:0] sd_rdata,
   input  logic              sd_out_valid,
   output logic              err_spurious
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              rw_q, owner_q, err_q;
   logic [1:0]        rsp_valid_q;
   logic [1:0]        grant;
   logic              last;
   logic              win;

   assign win = grant[1];

`ifdef SDRAM_ARB_RR_EN
   logic last_q;
   always_ff @(posedge clk) begin
      if (!rst)                last_q <= P1;
      else if (|req_ready)     last_q <= win;
   end
   assign last = last_q;
`else
   assign last = P1;
`endif

   sdram_arb_pick u_pick (
      .valid_i (req_valid),
      .last_i  (last),
      .grant_o (grant)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (|grant)       state_d = ST_ISSUE;
         ST_ISSUE:   if (!sd_busy)     state_d = rw_q ? ST_IDLE : ST_WAIT_RD;
         ST_WAIT_RD: if (sd_out_valid) state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // Gating with rst keeps the accept pulse quiet while reset is held.
   always_comb begin
      req_ready   = (state_q == ST_IDLE && rst) ? grant : 2'b00;
      sd_in_valid = (state_q == ST_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         rw_q        <= 1'b0;
         owner_q     <= P0;
         rsp_valid_q <= 2'b00;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (|req_ready) begin
            addr_q  <= win ? req_addr1  : req_addr0;
            wdata_q <= win ? req_wdata1 : req_wdata0;
            rw_q    <= req_rw[win];
            owner_q <= win;
         end
         rsp_valid_q <= 2'b00;
         if (sd_out_valid) begin
            if (state_q == ST_WAIT_RD) begin
               rsp_valid_q <= port_onehot(owner_q);
               rdata_q     <= sd_rdata;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign sd_addr      = addr_q;
   assign sd_rw        = rw_q;
   assign sd_wdata     = wdata_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign err_spurious = err_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter in front of `sdram_controller` that shares its single user interface (user_addr/rw/data_in/in_valid/busy/data_out/out_valid) between two requesters, e.g. CPU data port (port 0) and DMA/prefetch engine (port 1). It latches one request at a time, holds `in_valid` until the controller accepts it, and for reads holds the grant until `out_valid` returns and routes the data back to the owner. At most one operation is outstanding at the controller.

## Interface
- `ADDR_W`, 23, user address width (matches controller `user_addr`)
- `DATA_W`, 32, data width
- `clk` in 1: single clock, shared with `sdram_controller`
- `rst` in 1: reset, synchronous, active-low
- `req_valid` in 2: per-port request valid, held until `req_ready`
- `req_rw` in 2: per-port 1 = write, 0 = read
- `req_addr0`, `req_addr1` in ADDR_W: per-port address
- `req_wdata0`, `req_wdata1` in DATA_W: per-port write data
- `req_ready` out 2: one-cycle accept pulse, one-hot or zero
- `rsp_valid` out 2: one-cycle read-data pulse to the owning port
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid`, held afterward
- `sd_addr` out ADDR_W, `sd_rw` out 1, `sd_wdata` out DATA_W, `sd_in_valid` out 1: to controller
- `sd_busy` in 1, `sd_rdata` in DATA_W, `sd_out_valid` in 1: from controller
- `err_spurious` out 1: sticky, set on `sd_out_valid` outside WAIT_RD

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if any `req_valid`, pick winner, pulse `req_ready[winner]` (combinational from state and pick), latch addr/rw/wdata/owner into hold registers, go ISSUE.
- ISSUE: `sd_in_valid`=1 with held fields. Accept = `sd_in_valid && !sd_busy`. On accept: write → IDLE; read → WAIT_RD. Held fields are stable while in ISSUE.
- WAIT_RD: `sd_in_valid`=0. On `sd_out_valid`: capture `sd_rdata` into `rsp_rdata`, pulse `rsp_valid[owner]` next cycle, go IDLE.
- Pick: only one valid → that port. Both valid → per Configuration.
- Requester must hold `req_valid`/fields stable until `req_ready`; dropping `req_valid` before grant is permitted (request withdrawn).
- `sd_out_valid` in IDLE or ISSUE: ignored, sets `err_spurious`; cleared only by reset.
- Reset (any state): → IDLE, hold registers cleared, any in-flight controller operation discarded (controller is reset on the same reset).

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `sd_in_valid`=0, `sd_addr`=0, `sd_rw`=0, `sd_wdata`=0, `err_spurious`=0; last-grant register = 1 (port 0 wins first tie).
- Request cycle T (IDLE, `req_ready` pulse); `sd_in_valid` high from T+1.
- Controller idle: accepted at T+1; write back in IDLE at T+2 → back-to-back writes every 2 cycles.
- Read: `sd_out_valid` at cycle R → `rsp_valid` at R+1, IDLE at R+1, next `req_ready` earliest R+1.
- `sd_busy` high in ISSUE: `sd_in_valid` stays high, no timeout.
- No combinational path from `sd_*` inputs to `sd_*` outputs.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin; on tie grant the port not granted last; last-grant updates on every `req_ready`.
- Undefined: fixed priority, port 0 always wins a tie; last-grant register not built.

## Structure
- Package `sdram_arb_pkg`: state encoding (IDLE/ISSUE/WAIT_RD, 2 bits), `ADDR_W`/`DATA_W` defaults, port index constants.
- Sub-module `sdram_arb_pick`: 2-bit valid + last-grant in, one-hot grant out, macro-dependent; combinational.

## Test plan
- Port 0 write addr 0x000040 data 0xDEADBEEF, `sd_busy`=0 → `req_ready`=2'b01 at T, `sd_in_valid` only at T+1 with rw=1, IDLE at T+2.
- Port 1 read 0x000100, controller model returns 0x12345678 four cycles after accept → `rsp_valid`=2'b10 one cycle after `sd_out_valid`, `rsp_rdata`=0x12345678, `rsp_valid[0]` never high.
- Both ports request continuously, RR build → grants alternate 01,10,01,10; non-RR build → port 0 granted every time.
- `sd_busy` held high 5 cycles in ISSUE → `sd_in_valid` high 5 cycles with unchanged addr/data, accepted on 6th.
- `sd_out_valid` pulse while IDLE → `err_spurious`=1, no `rsp_valid`; stays 1 until reset.
- Reset asserted in WAIT_RD → next cycle IDLE, all outputs at reset values, late `sd_out_valid` after reset release sets `err_spurious`.
